pipeline_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage pipeline (fetch, IF/ID, decode, ID/EX, execute, EX/MEM, data memory, MEM/WB, write-back).
- Detects RAW hazards between the decode-stage operands and in-flight destinations, and generates PC/IF-ID write enables, ID/EX bubble insertion and EX-operand forwarding selects.
- Flushes younger stages when a branch resolves taken in MEM.
- Keeps saturating stall and flush event counters for performance debug.

---
 rtl/pipeline_hazard_ctrl_if.sv | 44 ++++
 rtl/pipeline_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the 5-stage pipeline datapath and its hazard controller.
// The pipeline side drives the master modport; the controller uses the slave modport.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic [4:0]       ex_rd;
  logic             ex_regwrite;
  logic             ex_memread;
  logic [4:0]       mem_rd;
  logic             mem_regwrite;
  logic [4:0]       wb_rd;
  logic             wb_regwrite;
  logic             mem_pcsrc;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [1:0]       dbgState;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread,
           mem_rd, mem_regwrite, wb_rd, wb_regwrite, mem_pcsrc,
    input  pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush,
           fwd_a, fwd_b, stall_cnt, flush_cnt, dbgState
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread,
           mem_rd, mem_regwrite, wb_rd, wb_regwrite, mem_pcsrc,
    output pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush,
           fwd_a, fwd_b, stall_cnt, flush_cnt, dbgState
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// RAW-hazard stall, branch flush and EX forwarding control for the 5-stage pipeline.
// Define FORWARDING_EN to enable EX/MEM and MEM/WB operand forwarding.
module pipeline_hazard_ctrl #(
  parameter int CNT_W     = 16,
  parameter int BR_SHADOW = 2
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int SW = (BR_SHADOW < 2) ? 1 : $clog2(BR_SHADOW + 1);

  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, SHADOW = 2'd2} ctrlState_t;

  ctrlState_t       state, nextState;
  logic [SW-1:0]    shadowLeft, nextShadow;
  logic [CNT_W-1:0] stallCnt, flushCnt;
  logic             hazard, flushNow, stallNow;

  // Register $0 is hard-wired, so a zero destination never matches.
  function automatic logic match(input logic [4:0] rd, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic usesRt);
    return (rd != 5'd0) && ((rd == rs) || (usesRt && rd == rt));
  endfunction

  always_comb begin
    hazard = (hz.ex_memread && hz.ex_regwrite &&
              match(hz.ex_rd, hz.id_rs, hz.id_rt, hz.id_uses_rt)) ||
             (hz.wb_regwrite && match(hz.wb_rd, hz.id_rs, hz.id_rt, hz.id_uses_rt));
`ifndef FORWARDING_EN
    // Without forwarding the consumer waits until its producer has left WB.
    hazard = hazard ||
             (hz.ex_regwrite && match(hz.ex_rd, hz.id_rs, hz.id_rt, hz.id_uses_rt)) ||
             (hz.mem_regwrite && match(hz.mem_rd, hz.id_rs, hz.id_rt, hz.id_uses_rt));
`endif
    flushNow = !rst && (state == RUN) && hz.mem_pcsrc;
    stallNow = !rst && !flushNow && hazard;
  end

  always_comb begin
    hz.pc_write    = 1'b1;
    hz.ifid_write  = 1'b1;
    hz.idex_bubble = 1'b0;
    hz.ifid_flush  = 1'b0;
    hz.idex_flush  = 1'b0;
    hz.exmem_flush = 1'b0;
    if (rst) begin
      hz.pc_write    = 1'b0;
      hz.ifid_write  = 1'b0;
      hz.idex_bubble = 1'b1;
      hz.ifid_flush  = 1'b1;
      hz.idex_flush  = 1'b1;
      hz.exmem_flush = 1'b1;
    end else if (flushNow) begin
      hz.ifid_flush  = 1'b1;
      hz.idex_flush  = 1'b1;
      hz.exmem_flush = 1'b1;
    end else if (stallNow) begin
      hz.pc_write    = 1'b0;
      hz.ifid_write  = 1'b0;
      hz.idex_bubble = 1'b1;
    end
  end

  always_comb begin
    hz.fwd_a = 2'b00;
    hz.fwd_b = 2'b00;
`ifdef FORWARDING_EN
    if (!rst) begin
      if (hz.mem_regwrite && hz.mem_rd != 5'd0 && hz.mem_rd == hz.ex_rs)
        hz.fwd_a = 2'b10;
      else if (hz.wb_regwrite && hz.wb_rd != 5'd0 && hz.wb_rd == hz.ex_rs)
        hz.fwd_a = 2'b01;
      if (hz.mem_regwrite && hz.mem_rd != 5'd0 && hz.mem_rd == hz.ex_rt)
        hz.fwd_b = 2'b10;
      else if (hz.wb_regwrite && hz.wb_rd != 5'd0 && hz.wb_rd == hz.ex_rt)
        hz.fwd_b = 2'b01;
    end
`endif
  end

  // Flushed slots still travel to MEM, so mem_pcsrc is ignored for BR_SHADOW cycles.
  always_comb begin
    nextState  = state;
    nextShadow = shadowLeft;
    case (state)
      RUN: if (hz.mem_pcsrc) nextState = FLUSH;
      FLUSH: begin
        if (BR_SHADOW > 1) begin
          nextState  = SHADOW;
          nextShadow = SW'(BR_SHADOW - 1);
        end else begin
          nextState = RUN;
        end
      end
      SHADOW: begin
        if (shadowLeft <= SW'(1)) begin
          nextState  = RUN;
          nextShadow = '0;
        end else begin
          nextShadow = shadowLeft - SW'(1);
        end
      end
      default: nextState = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      shadowLeft <= '0;
      stallCnt   <= '0;
      flushCnt   <= '0;
    end else begin
      state      <= nextState;
      shadowLeft <= nextShadow;
      if (stallNow && stallCnt != '1) stallCnt <= stallCnt + CNT_W'(1);
      if (flushNow && flushCnt != '1) flushCnt <= flushCnt + CNT_W'(1);
    end
  end

  assign hz.stall_cnt = stallCnt;
  assign hz.flush_cnt = flushCnt;
  assign hz.dbgState  = state;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a 16-bit-counter instance and a 4-bit-counter
// instance share the same stimulus so saturation can be checked alongside normal operation.
module tb_pipeline_hazard_ctrl;
  logic       clk;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rt, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite, mem_pcsrc;
  int         nChecks = 0;
  int         nPassed = 0;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) hz16();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  hz4();

  assign hz16.id_rs = id_rs;               assign hz4.id_rs = id_rs;
  assign hz16.id_rt = id_rt;               assign hz4.id_rt = id_rt;
  assign hz16.id_uses_rt = id_uses_rt;     assign hz4.id_uses_rt = id_uses_rt;
  assign hz16.ex_rs = ex_rs;               assign hz4.ex_rs = ex_rs;
  assign hz16.ex_rt = ex_rt;               assign hz4.ex_rt = ex_rt;
  assign hz16.ex_rd = ex_rd;               assign hz4.ex_rd = ex_rd;
  assign hz16.ex_regwrite = ex_regwrite;   assign hz4.ex_regwrite = ex_regwrite;
  assign hz16.ex_memread = ex_memread;     assign hz4.ex_memread = ex_memread;
  assign hz16.mem_rd = mem_rd;             assign hz4.mem_rd = mem_rd;
  assign hz16.mem_regwrite = mem_regwrite; assign hz4.mem_regwrite = mem_regwrite;
  assign hz16.wb_rd = wb_rd;               assign hz4.wb_rd = wb_rd;
  assign hz16.wb_regwrite = wb_regwrite;   assign hz4.wb_regwrite = wb_regwrite;
  assign hz16.mem_pcsrc = mem_pcsrc;       assign hz4.mem_pcsrc = mem_pcsrc;

  pipeline_hazard_ctrl #(.CNT_W(16), .BR_SHADOW(2)) dut16 (.clk(clk), .rst(rst), .hz(hz16));
  pipeline_hazard_ctrl #(.CNT_W(4),  .BR_SHADOW(2)) dut4  (.clk(clk), .rst(rst), .hz(hz4));

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
    mem_rd = 5'd0; mem_regwrite = 1'b0; wb_rd = 5'd0; wb_regwrite = 1'b0; mem_pcsrc = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic load_use();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
  endtask

  // Scenarios
  task automatic test_reset();
    idle();
    mem_pcsrc = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    nChecks++; if (hz16.pc_write !== 1'b0) $display("FAIL reset_pc_write: got %b want 0", hz16.pc_write); else nPassed++;
    nChecks++; if (hz16.ifid_write !== 1'b0) $display("FAIL reset_ifid_write: got %b want 0", hz16.ifid_write); else nPassed++;
    nChecks++; if (hz16.idex_bubble !== 1'b1) $display("FAIL reset_bubble: got %b want 1", hz16.idex_bubble); else nPassed++;
    nChecks++; if ({hz16.ifid_flush, hz16.idex_flush, hz16.exmem_flush} !== 3'b111) $display("FAIL reset_flushes: got %b want 111", {hz16.ifid_flush, hz16.idex_flush, hz16.exmem_flush}); else nPassed++;
    nChecks++; if ({hz16.fwd_a, hz16.fwd_b} !== 4'b0000) $display("FAIL reset_fwd: got %b want 0000", {hz16.fwd_a, hz16.fwd_b}); else nPassed++;
    nChecks++; if (hz16.stall_cnt !== 16'd0 || hz16.flush_cnt !== 16'd0) $display("FAIL reset_counters: got %0d/%0d want 0/0", hz16.stall_cnt, hz16.flush_cnt); else nPassed++;
    nChecks++; if (hz16.dbgState !== 2'd0) $display("FAIL reset_state: got %0d want 0", hz16.dbgState); else nPassed++;
    rst = 1'b0;
    mem_pcsrc = 1'b0;
    #1;
    nChecks++; if ({hz16.pc_write, hz16.ifid_write, hz16.idex_bubble} !== 3'b110) $display("FAIL run_after_reset: got %b want 110", {hz16.pc_write, hz16.ifid_write, hz16.idex_bubble}); else nPassed++;
    nChecks++; if ({hz16.ifid_flush, hz16.idex_flush, hz16.exmem_flush} !== 3'b000) $display("FAIL run_flushes: got %b want 000", {hz16.ifid_flush, hz16.idex_flush, hz16.exmem_flush}); else nPassed++;
  endtask

  task automatic test_load_use();
    do_reset();
    load_use();
    #1;
    nChecks++; if ({hz16.pc_write, hz16.ifid_write, hz16.idex_bubble} !== 3'b001) $display("FAIL loaduse_stall: got %b want 001", {hz16.pc_write, hz16.ifid_write, hz16.idex_bubble}); else nPassed++;
    nChecks++; if (hz16.ifid_flush !== 1'b0) $display("FAIL loaduse_noflush: got %b want 0", hz16.ifid_flush); else nPassed++;
    tick();
    nChecks++; if (hz16.stall_cnt !== 16'd1) $display("FAIL loaduse_cnt: got %0d want 1", hz16.stall_cnt); else nPassed++;
    ex_rd = 5'd0; id_rs = 5'd0;
    #1;
    nChecks++; if ({hz16.pc_write, hz16.idex_bubble} !== 2'b10) $display("FAIL loaduse_r0: got %b want 10", {hz16.pc_write, hz16.idex_bubble}); else nPassed++;
    tick();
    nChecks++; if (hz16.stall_cnt !== 16'd1) $display("FAIL loaduse_r0_cnt: got %0d want 1", hz16.stall_cnt); else nPassed++;
    ex_rd = 5'd12; id_rs = 5'd3; id_rt = 5'd12; id_uses_rt = 1'b0;
    #1;
    nChecks++; if (hz16.pc_write !== 1'b1) $display("FAIL rt_unused: got %b want 1", hz16.pc_write); else nPassed++;
    id_uses_rt = 1'b1;
    #1;
    nChecks++; if (hz16.pc_write !== 1'b0) $display("FAIL rt_used: got %b want 0", hz16.pc_write); else nPassed++;
    tick();
    nChecks++; if (hz16.stall_cnt !== 16'd2) $display("FAIL rt_cnt: got %0d want 2", hz16.stall_cnt); else nPassed++;
  endtask

  task automatic test_wb_hazard();
    do_reset();
    wb_regwrite = 1'b1; wb_rd = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1;
    #1;
    nChecks++; if (hz16.idex_bubble !== 1'b1) $display("FAIL wb_stall: got %b want 1", hz16.idex_bubble); else nPassed++;
    wb_rd = 5'd0; id_rt = 5'd0;
    #1;
    nChecks++; if (hz16.idex_bubble !== 1'b0) $display("FAIL wb_r0: got %b want 0", hz16.idex_bubble); else nPassed++;
  endtask

`ifdef FORWARDING_EN
  task automatic test_forwarding();
    do_reset();
    mem_regwrite = 1'b1; mem_rd = 5'd9; wb_regwrite = 1'b1; wb_rd = 5'd9; ex_rs = 5'd9;
    #1;
    nChecks++; if (hz16.fwd_a !== 2'b10) $display("FAIL fwd_a_mem: got %b want 10", hz16.fwd_a); else nPassed++;
    mem_regwrite = 1'b0;
    #1;
    nChecks++; if (hz16.fwd_a !== 2'b01) $display("FAIL fwd_a_wb: got %b want 01", hz16.fwd_a); else nPassed++;
    ex_rt = 5'd0; wb_rd = 5'd0;
    #1;
    nChecks++; if (hz16.fwd_b !== 2'b00) $display("FAIL fwd_b_r0: got %b want 00", hz16.fwd_b); else nPassed++;
    mem_regwrite = 1'b1; ex_rt = 5'd9;
    #1;
    nChecks++; if (hz16.fwd_b !== 2'b10) $display("FAIL fwd_b_mem: got %b want 10", hz16.fwd_b); else nPassed++;
    idle();
    ex_regwrite = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
    #1;
    nChecks++; if (hz16.pc_write !== 1'b1) $display("FAIL fwd_no_alu_stall: got %b want 1", hz16.pc_write); else nPassed++;
  endtask
`else
  task automatic test_no_forwarding();
    do_reset();
    ex_regwrite = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_rt = 5'd8; id_uses_rt = 1'b1;
    #1;
    nChecks++; if ({hz16.pc_write, hz16.fwd_a, hz16.fwd_b} !== 5'b00000) $display("FAIL nofwd_c1: got %b want 00000", {hz16.pc_write, hz16.fwd_a, hz16.fwd_b}); else nPassed++;
    tick();
    ex_regwrite = 1'b0; ex_rd = 5'd0; ex_rs = 5'd8; ex_rt = 5'd8;
    mem_regwrite = 1'b1; mem_rd = 5'd8;
    #1;
    nChecks++; if ({hz16.pc_write, hz16.fwd_a, hz16.fwd_b} !== 5'b00000) $display("FAIL nofwd_c2: got %b want 00000", {hz16.pc_write, hz16.fwd_a, hz16.fwd_b}); else nPassed++;
    tick();
    mem_regwrite = 1'b0; mem_rd = 5'd0; wb_regwrite = 1'b1; wb_rd = 5'd8;
    #1;
    nChecks++; if ({hz16.pc_write, hz16.fwd_a, hz16.fwd_b} !== 5'b00000) $display("FAIL nofwd_c3: got %b want 00000", {hz16.pc_write, hz16.fwd_a, hz16.fwd_b}); else nPassed++;
    tick();
    wb_regwrite = 1'b0; wb_rd = 5'd0;
    #1;
    nChecks++; if (hz16.pc_write !== 1'b1) $display("FAIL nofwd_c4: got %b want 1", hz16.pc_write); else nPassed++;
    nChecks++; if (hz16.stall_cnt !== 16'd3) $display("FAIL nofwd_cnt: got %0d want 3", hz16.stall_cnt); else nPassed++;
  endtask
`endif

  task automatic test_flush_over_stall();
    do_reset();
    load_use();
    mem_pcsrc = 1'b1;
    #1;
    nChecks++; if ({hz16.ifid_flush, hz16.idex_flush, hz16.exmem_flush} !== 3'b111) $display("FAIL flush_outs: got %b want 111", {hz16.ifid_flush, hz16.idex_flush, hz16.exmem_flush}); else nPassed++;
    nChecks++; if ({hz16.pc_write, hz16.idex_bubble} !== 2'b10) $display("FAIL flush_pc_bubble: got %b want 10", {hz16.pc_write, hz16.idex_bubble}); else nPassed++;
    tick();
    nChecks++; if (hz16.flush_cnt !== 16'd1 || hz16.stall_cnt !== 16'd0) $display("FAIL flush_cnts: got %0d/%0d want 1/0", hz16.flush_cnt, hz16.stall_cnt); else nPassed++;
    nChecks++; if (hz16.dbgState !== 2'd1) $display("FAIL flush_state: got %0d want 1", hz16.dbgState); else nPassed++;
    idle();
    mem_pcsrc = 1'b1;
    #1;
    nChecks++; if ({hz16.ifid_flush, hz16.pc_write} !== 2'b01) $display("FAIL shadow1_ignored: got %b want 01", {hz16.ifid_flush, hz16.pc_write}); else nPassed++;
    tick();
    nChecks++; if (hz16.dbgState !== 2'd2) $display("FAIL shadow_state: got %0d want 2", hz16.dbgState); else nPassed++;
    nChecks++; if (hz16.exmem_flush !== 1'b0) $display("FAIL shadow2_ignored: got %b want 0", hz16.exmem_flush); else nPassed++;
    tick();
    nChecks++; if (hz16.flush_cnt !== 16'd1 || hz16.dbgState !== 2'd0) $display("FAIL shadow_exit: got cnt %0d state %0d want 1/0", hz16.flush_cnt, hz16.dbgState); else nPassed++;
    nChecks++; if (hz16.idex_flush !== 1'b1) $display("FAIL reaccept: got %b want 1", hz16.idex_flush); else nPassed++;
    tick();
    nChecks++; if (hz16.flush_cnt !== 16'd2) $display("FAIL reaccept_cnt: got %0d want 2", hz16.flush_cnt); else nPassed++;
  endtask

  task automatic test_reset_in_shadow();
    do_reset();
    load_use();
    tick();
    idle();
    mem_pcsrc = 1'b1;
    tick();
    mem_pcsrc = 1'b0;
    tick();
    nChecks++; if (hz16.dbgState !== 2'd2 || hz16.stall_cnt !== 16'd1 || hz16.flush_cnt !== 16'd1) $display("FAIL pre_reset: got state %0d cnt %0d/%0d want 2 1/1", hz16.dbgState, hz16.stall_cnt, hz16.flush_cnt); else nPassed++;
    rst = 1'b1;
    #1;
    nChecks++; if ({hz16.pc_write, hz16.ifid_write, hz16.idex_bubble, hz16.exmem_flush} !== 4'b0011) $display("FAIL shadow_rst_outs: got %b want 0011", {hz16.pc_write, hz16.ifid_write, hz16.idex_bubble, hz16.exmem_flush}); else nPassed++;
    tick();
    rst = 1'b0;
    nChecks++; if (hz16.stall_cnt !== 16'd0 || hz16.flush_cnt !== 16'd0 || hz16.dbgState !== 2'd0) $display("FAIL shadow_rst_clear: got %0d/%0d state %0d want 0/0 0", hz16.stall_cnt, hz16.flush_cnt, hz16.dbgState); else nPassed++;
    mem_pcsrc = 1'b1;
    #1;
    nChecks++; if ({hz16.pc_write, hz16.ifid_flush} !== 2'b11) $display("FAIL post_rst_flush: got %b want 11", {hz16.pc_write, hz16.ifid_flush}); else nPassed++;
    tick();
    nChecks++; if (hz16.flush_cnt !== 16'd1) $display("FAIL post_rst_cnt: got %0d want 1", hz16.flush_cnt); else nPassed++;
  endtask

  task automatic test_saturation();
    do_reset();
    load_use();
    repeat (20) tick();
    nChecks++; if (hz4.stall_cnt !== 4'd15) $display("FAIL sat_cnt4: got %0d want 15", hz4.stall_cnt); else nPassed++;
    nChecks++; if (hz16.stall_cnt !== 16'd20) $display("FAIL sat_cnt16: got %0d want 20", hz16.stall_cnt); else nPassed++;
    nChecks++; if (hz4.idex_bubble !== 1'b1) $display("FAIL sat_bubble: got %b want 1", hz4.idex_bubble); else nPassed++;
  endtask

  // Sequence and final report
  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_wb_hazard();
`ifdef FORWARDING_EN
    test_forwarding();
`else
    test_no_forwarding();
`endif
    test_flush_over_stall();
    test_reset_in_shadow();
    test_saturation();
    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end
endmodule
